alua_sched: RTL

//  Owns the pipelined ALU A-input mux control word (alua_reg, one-hot, 15 bits) that feeds the alu/address-alu A mux.

---
 rtl/alua_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/alua_sched.sv
// ALU A-input mux control scheduler: arbitrates decoder single-cycle selects against
// atomic interrupt/restart sequences (SP-1, SP-1, vector load) and owns alua_reg.
module alua_sched #(
  parameter int unsigned AW    = 15,
  parameter int unsigned B_ONE = 0,
  parameter int unsigned B_M1  = 1,
  parameter int unsigned B_INT = 12,
  parameter int unsigned B_RST = 14
) (
  input  logic          clkc,
  input  logic          reset,
  input  logic          stall,
  input  logic          int_req,
  input  logic          rst_req,
  input  logic          dec_req,
  input  logic [AW-1:0] dec_sel,
  output logic          int_gnt,
  output logic          rst_gnt,
  output logic          dec_gnt,
  output logic          seq_done,
  output logic          busy,
  output logic          sel_err,
  output logic [AW-1:0] alua_reg
);

  // Source indices must be distinct and inside the control word.
  if (B_ONE >= AW || B_M1 >= AW || B_INT >= AW || B_RST >= AW ||
      B_ONE == B_M1 || B_INT == B_RST || B_M1 == B_INT || B_M1 == B_RST) begin : g_bad_param
    $error("alua_sched: invalid mux source bit indices");
  end

  localparam logic [AW-1:0] SEL_M1  = AW'(1) << B_M1;
  localparam logic [AW-1:0] SEL_INT = AW'(1) << B_INT;
  localparam logic [AW-1:0] SEL_RST = AW'(1) << B_RST;

  typedef enum logic [1:0] {IDLE, STEP2, STEP3} state_t;

  state_t state;
  logic   seq_is_rst;
  logic   sel_multi;

  assign sel_multi = (dec_sel & (dec_sel - AW'(1))) != '0;

  always_ff @(posedge clkc or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      seq_is_rst <= 1'b0;
      alua_reg   <= '0;
      int_gnt    <= 1'b0;
      rst_gnt    <= 1'b0;
      dec_gnt    <= 1'b0;
      seq_done   <= 1'b0;
      busy       <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      // Pulses clear every edge, stalled or not, so they never stretch.
      int_gnt  <= 1'b0;
      rst_gnt  <= 1'b0;
      dec_gnt  <= 1'b0;
      seq_done <= 1'b0;
      sel_err  <= 1'b0;
      if (!stall) begin
        case (state)
          IDLE: begin
            if (int_req) begin
              alua_reg   <= SEL_M1;
              int_gnt    <= 1'b1;
              seq_is_rst <= 1'b0;
              busy       <= 1'b1;
              state      <= STEP2;
            end else if (rst_req) begin
              alua_reg   <= SEL_M1;
              rst_gnt    <= 1'b1;
              seq_is_rst <= 1'b1;
              busy       <= 1'b1;
              state      <= STEP2;
            end else if (dec_req) begin
              dec_gnt <= 1'b1;
              if (sel_multi) begin
                alua_reg <= '0;
                sel_err  <= 1'b1;
              end else begin
                alua_reg <= dec_sel;
              end
            end else begin
              alua_reg <= '0;
            end
          end
          STEP2: begin
            alua_reg <= SEL_M1;
            state    <= STEP3;
          end
          STEP3: begin
            alua_reg <= seq_is_rst ? SEL_RST : SEL_INT;
            seq_done <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            alua_reg <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
